// File: rtl/hawk_pkg.sv
// Shared types and default timing for the Hawk sensor emulator.
package hawk_pkg;

    localparam int HAWK_DATA_W     = 14;

    localparam int DEF_LINE_WIDTH  = 640;
    localparam int DEF_FRAME_LINES = 512;
    localparam int DEF_HBLANK      = 32;
    localparam int DEF_VBLANK      = 64;
    localparam int DEF_FV2LV       = 4;
    localparam int DEF_LV2FV       = 4;
    localparam int DEF_FIFO_DEPTH  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FV_LEAD,
        ST_LINE,
        ST_HBLANK,
        ST_FV_TRAIL,
        ST_VBLANK
    } hawk_state_t;

    typedef enum logic {
        SK_HUNT,
        SK_SYNCED
    } sink_state_t;

endpackage

// File: rtl/hawk_line_fifo.sv
// Show-ahead pixel buffer with an occupancy level output.
// Latency: head word visible combinationally; push and pop in one cycle leave the level unchanged.
// Backpressure: none internally; the caller gates push on level and pop on occupancy.
module hawk_line_fifo #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_push_dat,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_head_dat,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_level    = r_level;

endmodule

// File: rtl/hawk_sensor_emu.sv
// Replays an Avalon-ST pixel stream as Hawk FVAL/LVAL/data timing; HAWK_EMU_PATTERN_EN adds a test-pattern mode.
// Latency: a line starts only once LINE_WIDTH pixels are buffered; outputs are registered.
// Backpressure: stream_ready drops when the buffer is full; blanking stretches while a line is incomplete.
module hawk_sensor_emu
    import hawk_pkg::*;
#(
    parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
    parameter int FRAME_LINES = DEF_FRAME_LINES,
    parameter int HBLANK      = DEF_HBLANK,
    parameter int VBLANK      = DEF_VBLANK,
    parameter int FV2LV       = DEF_FV2LV,
    parameter int LV2FV       = DEF_LV2FV,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                   hawk_clk,
    input  logic                   hawk_rst,
    input  logic                   enable,
`ifdef HAWK_EMU_PATTERN_EN
    input  logic                   pattern_mode,
`endif
    input  logic                   stream_valid,
    input  logic                   stream_sop,
    input  logic                   stream_eop,
    input  logic [15:0]            stream_data,
    output logic                   stream_ready,
    output logic                   hawk_FVAL,
    output logic                   hawk_LVAL,
    output logic [HAWK_DATA_W-1:0] hawk_data,
    output logic                   frame_done,
    output logic                   sync_err
);
    localparam int FRAME_PIX = LINE_WIDTH * FRAME_LINES;
    localparam int PIX_W     = $clog2(FRAME_PIX);
    localparam int COL_W     = $clog2(LINE_WIDTH);
    localparam int LN_W      = $clog2(FRAME_LINES);
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int BLK_W     = 16;

    logic [LVL_W-1:0]       w_level;
    logic [HAWK_DATA_W-1:0] w_head;
    logic                   w_xfer, w_push, w_pop;
    logic [PIX_W-1:0]       w_cnt_base;
    logic                   w_unused_hi;

    sink_state_t            r_sink;
    logic [PIX_W-1:0]       r_pix_cnt;
    logic                   r_sync_err;

    assign stream_ready = !hawk_rst && (w_level < LVL_W'(FIFO_DEPTH));
    assign w_xfer       = stream_valid && stream_ready;
    assign w_push       = w_xfer && (stream_sop || r_sink == SK_SYNCED);
    assign w_cnt_base   = stream_sop ? '0 : r_pix_cnt;
    assign w_unused_hi  = ^stream_data[15:HAWK_DATA_W];

    // w_cnt_base is the number of words before this one, so a correct eop sees FRAME_PIX-1.
    always_ff @(posedge hawk_clk or posedge hawk_rst) begin
        if (hawk_rst) begin
            r_sink     <= SK_HUNT;
            r_pix_cnt  <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= 1'b0;
            if (w_push) begin
                r_sink <= SK_SYNCED;
                if (stream_sop && r_pix_cnt != '0) r_sync_err <= 1'b1;
                if (stream_eop) begin
                    r_pix_cnt <= '0;
                    if (w_cnt_base != PIX_W'(FRAME_PIX - 1)) r_sync_err <= 1'b1;
                end else begin
                    r_pix_cnt <= w_cnt_base + 1'b1;
                end
            end
        end
    end

    hawk_line_fifo #(
        .DATA_W (HAWK_DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_line_fifo (
        .i_clk      (hawk_clk),
        .i_rst      (hawk_rst),
        .i_push     (w_push),
        .i_push_dat (stream_data[HAWK_DATA_W-1:0]),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_level    (w_level)
    );

    hawk_state_t            r_state;
    logic [BLK_W-1:0]       r_blk;
    logic [COL_W-1:0]       r_col;
    logic [LN_W-1:0]        r_line;
    logic                   r_fval, r_lval, r_frame_done;
    logic [HAWK_DATA_W-1:0] r_data;

    logic                   w_pat, w_start, w_have_line, w_line_go, w_emit, w_col_last;
    logic [COL_W-1:0]       w_next_col;
    logic [HAWK_DATA_W-1:0] w_pix_dat;

    assign w_have_line = w_level >= LVL_W'(LINE_WIDTH);

`ifdef HAWK_EMU_PATTERN_EN
    logic r_pat;

    always_ff @(posedge hawk_clk or posedge hawk_rst) begin
        if (hawk_rst)                 r_pat <= 1'b0;
        else if (r_state == ST_IDLE)  r_pat <= pattern_mode;
    end

    assign w_pat   = r_pat;
    assign w_start = enable && (pattern_mode || w_have_line);
`else
    assign w_pat   = 1'b0;
    assign w_start = enable && w_have_line;
`endif

    assign w_line_go  = w_pat || w_have_line;
    assign w_col_last = r_col == COL_W'(LINE_WIDTH - 1);
    assign w_next_col = (r_state == ST_LINE) ? r_col + 1'b1 : '0;
    // Cycles in which the next pixel is loaded into the output register.
    assign w_emit     = (r_state == ST_FV_LEAD && r_blk == '0) ||
                        (r_state == ST_HBLANK  && r_blk == '0 && w_line_go) ||
                        (r_state == ST_LINE    && !w_col_last);
    assign w_pop      = w_emit && !w_pat;
    assign w_pix_dat  = w_pat ? HAWK_DATA_W'(w_next_col) + HAWK_DATA_W'(r_line) : w_head;

    always_ff @(posedge hawk_clk or posedge hawk_rst) begin
        if (hawk_rst) begin
            r_state      <= ST_IDLE;
            r_blk        <= '0;
            r_col        <= '0;
            r_line       <= '0;
            r_fval       <= 1'b0;
            r_lval       <= 1'b0;
            r_data       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_emit) begin
                r_lval <= 1'b1;
                r_data <= w_pix_dat;
                r_col  <= w_next_col;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_FV_LEAD;
                        r_fval  <= 1'b1;
                        r_blk   <= BLK_W'(FV2LV - 1);
                        r_line  <= '0;
                    end
                end
                ST_FV_LEAD: begin
                    if (r_blk == '0) r_state <= ST_LINE;
                    else             r_blk   <= r_blk - 1'b1;
                end
                ST_LINE: begin
                    if (w_col_last) begin
                        r_lval <= 1'b0;
                        r_data <= '0;
                        if (r_line == LN_W'(FRAME_LINES - 1)) begin
                            r_state <= ST_FV_TRAIL;
                            r_blk   <= BLK_W'(LV2FV - 1);
                        end else begin
                            r_state <= ST_HBLANK;
                            r_blk   <= BLK_W'(HBLANK - 1);
                            r_line  <= r_line + 1'b1;
                        end
                    end
                end
                ST_HBLANK: begin
                    if (r_blk != '0)    r_blk   <= r_blk - 1'b1;
                    else if (w_line_go) r_state <= ST_LINE;
                end
                ST_FV_TRAIL: begin
                    if (r_blk == '0) begin
                        r_state      <= ST_VBLANK;
                        r_fval       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_blk        <= BLK_W'(VBLANK - 1);
                    end else begin
                        r_blk <= r_blk - 1'b1;
                    end
                end
                ST_VBLANK: begin
                    if (r_blk == '0) r_state <= ST_IDLE;
                    else             r_blk   <= r_blk - 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign hawk_FVAL  = r_fval;
    assign hawk_LVAL  = r_lval;
    assign hawk_data  = r_data;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_hawk_sensor_emu.sv
// Directed bench for hawk_sensor_emu with a small 8x4 frame geometry.
module tb_hawk_sensor_emu;
    localparam int NPIX = 32;

    logic        hawk_clk = 1'b0;
    logic        hawk_rst = 1'b1;
    logic        enable = 1'b0;
    logic        stream_valid = 1'b0;
    logic        stream_sop = 1'b0;
    logic        stream_eop = 1'b0;
    logic [15:0] stream_data = '0;
    logic        stream_ready, hawk_FVAL, hawk_LVAL, frame_done, sync_err;
    logic [13:0] hawk_data;

    int errors = 0;
    int checks = 0;

    hawk_sensor_emu #(
        .LINE_WIDTH(8), .FRAME_LINES(4), .HBLANK(3), .VBLANK(5),
        .FV2LV(2), .LV2FV(2), .FIFO_DEPTH(16)
    ) dut (
        .hawk_clk(hawk_clk), .hawk_rst(hawk_rst), .enable(enable),
        .stream_valid(stream_valid), .stream_sop(stream_sop), .stream_eop(stream_eop),
        .stream_data(stream_data), .stream_ready(stream_ready),
        .hawk_FVAL(hawk_FVAL), .hawk_LVAL(hawk_LVAL), .hawk_data(hawk_data),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 hawk_clk = ~hawk_clk;

    // Output observer: records pixels, burst lengths, FVAL lengths, blanking gaps and pulses.
    logic [13:0] q_pix[$];
    int q_burst[$], q_fval[$], q_gap[$];
    int m_run = 0, m_fv_run = 0, m_gap = 0, m_fd = 0, m_se = 0, m_dz = 0;
    bit m_prev_lv = 0, m_had_line = 0;

    always @(negedge hawk_clk) begin
        if (hawk_LVAL) begin
            if (!m_prev_lv && m_had_line) q_gap.push_back(m_gap);
            q_pix.push_back(hawk_data);
            m_run++;
            m_had_line = 1;
        end else begin
            if (m_run != 0) begin
                q_burst.push_back(m_run);
                m_run = 0;
                m_gap = 0;
            end
            if (hawk_FVAL) m_gap++;
            if (hawk_data != 0) m_dz++;
        end
        if (hawk_FVAL) m_fv_run++;
        else begin
            if (m_fv_run != 0) q_fval.push_back(m_fv_run);
            m_fv_run = 0;
            m_had_line = 0;
        end
        if (frame_done) m_fd++;
        if (sync_err) m_se++;
        m_prev_lv = hawk_LVAL;
    end

    task automatic push_word(input int d, input bit sop, input bit eop);
        bit got;
        int t;
        got = 0;
        t = 0;
        stream_valid = 1'b1;
        stream_data  = {2'b11, 14'(d)};
        stream_sop   = sop;
        stream_eop   = eop;
        while (!got && t < 2000) begin
            @(negedge hawk_clk);
            got = stream_ready;
            @(posedge hawk_clk);
            #1;
            t++;
        end
        stream_valid = 1'b0;
        stream_sop   = 1'b0;
        stream_eop   = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL push_timeout word=%0d ready never seen", d);
        end
    endtask

    task automatic push_frame(input int base, input bit toggle, input int sop2);
        for (int i = 0; i < NPIX; i++) begin
            push_word(base + i, (i == 0) || (i == sop2), i == NPIX - 1);
            if (toggle && (i % 4 == 3)) begin
                repeat (4) @(posedge hawk_clk);
                #1;
            end
        end
    endtask

    task automatic wait_frame(input int fd0);
        int t;
        t = 0;
        while (m_fd == fd0 && t < 3000) begin
            @(posedge hawk_clk);
            t++;
        end
        if (m_fd == fd0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout frame_done never pulsed");
        end
        repeat (10) @(posedge hawk_clk);
        #1;
    endtask

    task automatic apply_reset();
        hawk_rst = 1'b1;
        repeat (3) @(posedge hawk_clk);
        #1;
        hawk_rst = 1'b0;
        @(posedge hawk_clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge hawk_clk);
        #1;
        checks++; if (stream_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", stream_ready); end
        checks++; if ({hawk_FVAL, hawk_LVAL, frame_done, sync_err} !== 4'b0000) begin errors++; $display("FAIL rst_ctrl got=%b exp=0000", {hawk_FVAL, hawk_LVAL, frame_done, sync_err}); end
        checks++; if (hawk_data !== 14'd0) begin errors++; $display("FAIL rst_data got=%0d exp=0", hawk_data); end
        hawk_rst = 1'b0;
        @(posedge hawk_clk);
        #1;
        checks++; if (stream_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%b exp=1", stream_ready); end
    endtask

    task automatic test_basic_frame();
        int pb, bb, fb, gb, fd0, se0, dz0;
        pb = q_pix.size(); bb = q_burst.size(); fb = q_fval.size(); gb = q_gap.size();
        fd0 = m_fd; se0 = m_se; dz0 = m_dz;
        enable = 1'b1;
        push_frame(0, 0, -1);
        wait_frame(fd0);
        enable = 1'b0;
        checks++; if (q_fval.size() - fb !== 1) begin errors++; $display("FAIL basic_fval_count got=%0d exp=1", q_fval.size() - fb); end
        if (q_fval.size() > fb) begin
            checks++; if (q_fval[fb] !== 45) begin errors++; $display("FAIL basic_fval_len got=%0d exp=45", q_fval[fb]); end
        end
        checks++; if (q_burst.size() - bb !== 4) begin errors++; $display("FAIL basic_bursts got=%0d exp=4", q_burst.size() - bb); end
        for (int i = bb; i < q_burst.size(); i++) begin
            checks++; if (q_burst[i] !== 8) begin errors++; $display("FAIL basic_burst_len got=%0d exp=8", q_burst[i]); end
        end
        for (int i = gb; i < q_gap.size(); i++) begin
            checks++; if (q_gap[i] !== 3) begin errors++; $display("FAIL basic_hblank got=%0d exp=3", q_gap[i]); end
        end
        checks++; if (q_pix.size() - pb !== NPIX) begin errors++; $display("FAIL basic_pix_count got=%0d exp=%0d", q_pix.size() - pb, NPIX); end
        for (int i = 0; i < NPIX && pb + i < q_pix.size(); i++) begin
            checks++; if (q_pix[pb + i] !== 14'(i)) begin errors++; $display("FAIL basic_pix[%0d] got=%0d exp=%0d", i, q_pix[pb + i], i); end
        end
        checks++; if (m_fd - fd0 !== 1) begin errors++; $display("FAIL basic_frame_done got=%0d exp=1", m_fd - fd0); end
        checks++; if (m_se - se0 !== 0) begin errors++; $display("FAIL basic_sync_err got=%0d exp=0", m_se - se0); end
        checks++; if (m_dz - dz0 !== 0) begin errors++; $display("FAIL basic_data_idle_zero got=%0d exp=0", m_dz - dz0); end
    endtask

    task automatic test_slow_source();
        int pb, bb, fb, gb, fd0, max_gap;
        pb = q_pix.size(); bb = q_burst.size(); fb = q_fval.size(); gb = q_gap.size();
        fd0 = m_fd;
        enable = 1'b1;
        push_frame(100, 1, -1);
        wait_frame(fd0);
        enable = 1'b0;
        checks++; if (q_burst.size() - bb !== 4) begin errors++; $display("FAIL slow_bursts got=%0d exp=4", q_burst.size() - bb); end
        for (int i = bb; i < q_burst.size(); i++) begin
            checks++; if (q_burst[i] !== 8) begin errors++; $display("FAIL slow_burst_len got=%0d exp=8", q_burst[i]); end
        end
        max_gap = 0;
        for (int i = gb; i < q_gap.size(); i++) begin
            if (q_gap[i] > max_gap) max_gap = q_gap[i];
            checks++; if (q_gap[i] < 3) begin errors++; $display("FAIL slow_hblank_min got=%0d exp>=3", q_gap[i]); end
        end
        checks++; if (max_gap <= 3) begin errors++; $display("FAIL slow_hblank_stretch got=%0d exp>3", max_gap); end
        if (q_fval.size() > fb) begin
            checks++; if (q_fval[fb] <= 45) begin errors++; $display("FAIL slow_fval_len got=%0d exp>45", q_fval[fb]); end
        end
        checks++; if (q_pix.size() - pb !== NPIX) begin errors++; $display("FAIL slow_pix_count got=%0d exp=%0d", q_pix.size() - pb, NPIX); end
        for (int i = 0; i < NPIX && pb + i < q_pix.size(); i++) begin
            checks++; if (q_pix[pb + i] !== 14'(100 + i)) begin errors++; $display("FAIL slow_pix[%0d] got=%0d exp=%0d", i, q_pix[pb + i], 100 + i); end
        end
    endtask

    task automatic test_backpressure();
        int pb, fd0;
        pb = q_pix.size(); fd0 = m_fd;
        enable = 1'b0;
        for (int i = 0; i < 16; i++) push_word(200 + i, i == 0, 1'b0);
        stream_valid = 1'b1;
        stream_data  = {2'b00, 14'd216};
        @(negedge hawk_clk);
        checks++; if (stream_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b exp=0", stream_ready); end
        repeat (4) @(negedge hawk_clk);
        checks++; if (stream_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold got=%b exp=0", stream_ready); end
        checks++; if (hawk_FVAL !== 1'b0) begin errors++; $display("FAIL bp_idle_fval got=%b exp=0", hawk_FVAL); end
        enable = 1'b1;
        for (int i = 16; i < NPIX; i++) push_word(200 + i, 1'b0, i == NPIX - 1);
        wait_frame(fd0);
        enable = 1'b0;
        checks++; if (q_pix.size() - pb !== NPIX) begin errors++; $display("FAIL bp_pix_count got=%0d exp=%0d", q_pix.size() - pb, NPIX); end
        for (int i = 0; i < NPIX && pb + i < q_pix.size(); i++) begin
            checks++; if (q_pix[pb + i] !== 14'(200 + i)) begin errors++; $display("FAIL bp_pix[%0d] got=%0d exp=%0d", i, q_pix[pb + i], 200 + i); end
        end
    endtask

    task automatic test_hunt();
        int pb, fd0, se0;
        apply_reset();
        pb = q_pix.size(); fd0 = m_fd; se0 = m_se;
        for (int i = 0; i < 3; i++) push_word(9000 + i, 1'b0, 1'b0);
        enable = 1'b1;
        push_frame(300, 0, -1);
        wait_frame(fd0);
        enable = 1'b0;
        checks++; if (q_pix.size() - pb !== NPIX) begin errors++; $display("FAIL hunt_pix_count got=%0d exp=%0d", q_pix.size() - pb, NPIX); end
        if (q_pix.size() > pb) begin
            checks++; if (q_pix[pb] !== 14'd300) begin errors++; $display("FAIL hunt_first_pix got=%0d exp=300", q_pix[pb]); end
        end
        checks++; if (m_se - se0 !== 0) begin errors++; $display("FAIL hunt_sync_err got=%0d exp=0", m_se - se0); end
    endtask

    task automatic test_sync_err();
        int pb, fd0, se0;
        pb = q_pix.size(); fd0 = m_fd; se0 = m_se;
        enable = 1'b1;
        push_frame(600, 0, 10);
        wait_frame(fd0);
        enable = 1'b0;
        checks++; if (m_se - se0 !== 2) begin errors++; $display("FAIL sync_err_pulses got=%0d exp=2", m_se - se0); end
        checks++; if (q_pix.size() - pb !== NPIX) begin errors++; $display("FAIL sync_pix_count got=%0d exp=%0d", q_pix.size() - pb, NPIX); end
        if (q_pix.size() > pb + 10) begin
            checks++; if (q_pix[pb + 10] !== 14'd610) begin errors++; $display("FAIL sync_resop_pix got=%0d exp=610", q_pix[pb + 10]); end
        end
    endtask

    task automatic test_reset_mid_line();
        int t, pb, bb, fd0, se0;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) push_word(400 + i, i == 0, 1'b0);
        t = 0;
        while (!hawk_LVAL && t < 200) begin
            @(negedge hawk_clk);
            t++;
        end
        @(posedge hawk_clk);
        #2;
        checks++; if (hawk_LVAL !== 1'b1) begin errors++; $display("FAIL mid_line_pre got=%b exp=1", hawk_LVAL); end
        hawk_rst = 1'b1;
        #1;
        checks++; if ({hawk_FVAL, hawk_LVAL} !== 2'b00) begin errors++; $display("FAIL async_rst_ctrl got=%b exp=00", {hawk_FVAL, hawk_LVAL}); end
        checks++; if (hawk_data !== 14'd0) begin errors++; $display("FAIL async_rst_data got=%0d exp=0", hawk_data); end
        checks++; if (stream_ready !== 1'b0) begin errors++; $display("FAIL async_rst_ready got=%b exp=0", stream_ready); end
        repeat (3) @(posedge hawk_clk);
        #1;
        hawk_rst = 1'b0;
        @(posedge hawk_clk);
        #1;
        pb = q_pix.size(); bb = q_burst.size(); fd0 = m_fd; se0 = m_se;
        for (int i = 12; i < 16; i++) push_word(400 + i, 1'b0, 1'b0);
        push_frame(500, 0, -1);
        wait_frame(fd0);
        enable = 1'b0;
        checks++; if (q_burst.size() - bb !== 4) begin errors++; $display("FAIL post_rst_bursts got=%0d exp=4", q_burst.size() - bb); end
        checks++; if (q_pix.size() - pb !== NPIX) begin errors++; $display("FAIL post_rst_pix_count got=%0d exp=%0d", q_pix.size() - pb, NPIX); end
        for (int i = 0; i < NPIX && pb + i < q_pix.size(); i++) begin
            checks++; if (q_pix[pb + i] !== 14'(500 + i)) begin errors++; $display("FAIL post_rst_pix[%0d] got=%0d exp=%0d", i, q_pix[pb + i], 500 + i); end
        end
        checks++; if (m_fd - fd0 !== 1) begin errors++; $display("FAIL post_rst_frame_done got=%0d exp=1", m_fd - fd0); end
        checks++; if (m_se - se0 !== 0) begin errors++; $display("FAIL post_rst_sync_err got=%0d exp=0", m_se - se0); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_slow_source();
        test_backpressure();
        test_hunt();
        test_sync_err();
        test_reset_mid_line();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
